// File: rtl/pipe_stage_skid_pkg.sv
// Shared types for the generic pipeline boundary register: occupancy/state
// codes and the ID/EX payload layout with its NOP bubble pattern.
package pipe_stage_skid_pkg;

    localparam int unsigned OCC_W = 2;

    // State code doubles as the occupancy count.
    typedef enum logic [OCC_W-1:0] {
        PIPE_EMPTY = 2'd0,
        PIPE_ONE   = 2'd1,
        PIPE_TWO   = 2'd2
    } pipe_state_e;

    localparam int unsigned ALU_OP_W    = 4;
    localparam int unsigned JUMP_OP_W   = 2;
    localparam int unsigned BRANCH_OP_W = 3;
    localparam int unsigned REG_ADDR_W  = 5;
    localparam int unsigned WORD_W      = 32;

    localparam logic [ALU_OP_W-1:0]    NO_ALU        = ALU_OP_W'(0);
    localparam logic [JUMP_OP_W-1:0]   NO_JUMP       = JUMP_OP_W'(0);
    localparam logic [BRANCH_OP_W-1:0] NO_BRANCH     = BRANCH_OP_W'(0);
    localparam logic                   WRITE_DISABLE = 1'b0;
    localparam logic [WORD_W-1:0]      ZERO_WORD     = WORD_W'(0);

    // ID/EX stage fields, packed into one bus at the stage boundary.
    typedef struct packed {
        logic [ALU_OP_W-1:0]    alu_op;
        logic [JUMP_OP_W-1:0]   jump_op;
        logic [BRANCH_OP_W-1:0] branch_op;
        logic                   wr_en;
        logic [REG_ADDR_W-1:0]  wr_addr;
        logic [WORD_W-1:0]      rs1_val;
        logic [WORD_W-1:0]      rs2_val;
        logic [WORD_W-1:0]      imm;
    } id_ex_payload_t;

    localparam int unsigned ID_EX_W = $bits(id_ex_payload_t);

    localparam id_ex_payload_t NOP_ID_EX = '{
        alu_op:    NO_ALU,
        jump_op:   NO_JUMP,
        branch_op: NO_BRANCH,
        wr_en:     WRITE_DISABLE,
        wr_addr:   REG_ADDR_W'(0),
        rs1_val:   ZERO_WORD,
        rs2_val:   ZERO_WORD,
        imm:       ZERO_WORD
    };

    function automatic logic [OCC_W-1:0] state_occupancy(input pipe_state_e s);
        return OCC_W'(s);
    endfunction

endpackage

// File: rtl/pipe_stage_skid.sv
// Generic valid/ready pipeline boundary register with optional 2-entry skid,
// bubble insertion on empty and flush on redirect.
module pipe_stage_skid
    import pipe_stage_skid_pkg::*;
#(
    parameter int unsigned        DATA_W          = 32,
    parameter logic [DATA_W-1:0]  BUBBLE          = '0,
    parameter bit                 SKID            = 1'b1,
    parameter bit                 CLEAR_ON_BUBBLE = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [1:0]        occupancy
);

    pipe_state_e       state_q, state_d;
    logic [DATA_W-1:0] main_q, main_d;
    logic [DATA_W-1:0] skid_q, skid_d;
    logic              out_valid_q;
    logic              accept;
    logic              consume;
    logic [DATA_W-1:0] empty_data;

    assign accept     = in_valid && in_ready;
    assign consume    = out_valid_q && out_ready;
    // Payload left in main when the stage drains: bubble or last instruction.
    assign empty_data = CLEAR_ON_BUBBLE ? BUBBLE : main_q;

    // Next-state and storage update; flush overrides every handshake.
    always_comb begin
        state_d = state_q;
        main_d  = main_q;
        skid_d  = skid_q;

        case (state_q)
            PIPE_EMPTY: begin
                if (accept) begin
                    state_d = PIPE_ONE;
                    main_d  = in_data;
                end
            end
            PIPE_ONE: begin
                if (accept && consume) begin
                    main_d = in_data;
                end else if (accept) begin
                    if (SKID) begin
                        state_d = PIPE_TWO;
                        skid_d  = in_data;
                    end
                end else if (consume) begin
                    state_d = PIPE_EMPTY;
                    main_d  = empty_data;
                end
            end
            PIPE_TWO: begin
                if (consume) begin
                    state_d = PIPE_ONE;
                    main_d  = skid_q;
                end
            end
            default: begin
                state_d = PIPE_EMPTY;
                main_d  = empty_data;
            end
        endcase

        if (flush) begin
            state_d = PIPE_EMPTY;
            main_d  = empty_data;
        end
    end

    // State and payload registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= PIPE_EMPTY;
            main_q      <= BUBBLE;
            skid_q      <= BUBBLE;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            main_q      <= main_d;
            skid_q      <= skid_d;
            out_valid_q <= (state_d != PIPE_EMPTY);
        end
    end

    generate
        if (SKID) begin : g_skid
            logic in_ready_q;

            // Registered ready: the skid entry absorbs the one-cycle lag.
            always_ff @(posedge clk) begin
                if (rst) begin
                    in_ready_q <= 1'b1;
                end else begin
                    in_ready_q <= (state_d != PIPE_TWO);
                end
            end

            assign in_ready = in_ready_q;
        end else begin : g_noskid
            assign in_ready = !out_valid_q || out_ready;
        end
    endgenerate

    assign out_valid = out_valid_q;
    assign out_data  = main_q;
    assign occupancy = state_occupancy(state_q);

endmodule

// File: tb/tb_pipe_stage_skid.sv
// Self-checking bench: directed vector table on the skid variant, then random
// traffic on both variants against a queue-level reference model.
module tb_pipe_stage_skid;

    logic        clk = 1'b0;
    logic        rst_s   [2];
    logic        flush_s [2];
    logic        iv_s    [2];
    logic        ir_s    [2];
    logic [31:0] id_s    [2];
    logic        ov_s    [2];
    logic        ordy_s  [2];
    logic [31:0] od_s    [2];
    logic [1:0]  occ_s   [2];

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    // Unit 1: SKID=1, unit 0: SKID=0.
    pipe_stage_skid #(.DATA_W(32), .BUBBLE(32'h0), .SKID(1'b1), .CLEAR_ON_BUBBLE(1'b1)) u_dut1 (
        .clk(clk), .rst(rst_s[1]), .flush(flush_s[1]),
        .in_valid(iv_s[1]), .in_ready(ir_s[1]), .in_data(id_s[1]),
        .out_valid(ov_s[1]), .out_ready(ordy_s[1]), .out_data(od_s[1]),
        .occupancy(occ_s[1])
    );

    pipe_stage_skid #(.DATA_W(32), .BUBBLE(32'h0), .SKID(1'b0), .CLEAR_ON_BUBBLE(1'b1)) u_dut0 (
        .clk(clk), .rst(rst_s[0]), .flush(flush_s[0]),
        .in_valid(iv_s[0]), .in_ready(ir_s[0]), .in_data(id_s[0]),
        .out_valid(ov_s[0]), .out_ready(ordy_s[0]), .out_data(od_s[0]),
        .occupancy(occ_s[0])
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    typedef struct {
        logic        rst;
        logic        flush;
        logic        iv;
        logic [31:0] d;
        logic        ordy;
        logic        ov;
        logic [31:0] od;
        logic        ir;
        logic        chk_ir;
        logic [1:0]  occ;
    } vec_t;

    vec_t tbl[$];

    task automatic add(input logic r, input logic f, input logic v, input logic [31:0] d,
                       input logic o, input logic eov, input logic [31:0] eod,
                       input logic eir, input logic cir, input logic [1:0] eocc);
        vec_t t;
        t.rst = r; t.flush = f; t.iv = v; t.d = d; t.ordy = o;
        t.ov = eov; t.od = eod; t.ir = eir; t.chk_ir = cir; t.occ = eocc;
        tbl.push_back(t);
    endtask

    // Reference model: a FIFO of capacity 2 (skid) or 1 (no skid).
    logic [31:0] mdl_mem [2][2];
    int          mdl_cnt [2];

    task automatic cyc(input int u, input logic r, input logic f, input logic v,
                       input logic [31:0] d, input logic o);
        logic exp_ir;
        logic acc;
        logic cons;
        rst_s[u] = r; flush_s[u] = f; iv_s[u] = v; id_s[u] = d; ordy_s[u] = o;
        #1;
        exp_ir = (u == 1) ? (mdl_cnt[u] != 2) : (mdl_cnt[u] == 0 || o);
        if (!r) chk(u == 1 ? "in_ready_skid" : "in_ready_noskid", 32'(ir_s[u]), 32'(exp_ir));
        acc  = v && exp_ir;
        cons = (mdl_cnt[u] > 0) && o;
        if (r || f) begin
            mdl_cnt[u] = 0;
        end else begin
            if (cons) begin
                mdl_mem[u][0] = mdl_mem[u][1];
                mdl_cnt[u]--;
            end
            if (acc) begin
                mdl_mem[u][mdl_cnt[u]] = d;
                mdl_cnt[u]++;
            end
        end
        @(posedge clk);
        #1;
        chk("out_valid", 32'(ov_s[u]), 32'(mdl_cnt[u] > 0));
        chk("out_data", od_s[u], (mdl_cnt[u] > 0) ? mdl_mem[u][0] : 32'h0);
        chk("occupancy", 32'(occ_s[u]), 32'(mdl_cnt[u]));
    endtask

    initial begin
        for (int u = 0; u < 2; u++) begin
            rst_s[u] = 1'b1; flush_s[u] = 1'b0; iv_s[u] = 1'b0;
            id_s[u] = 32'h0; ordy_s[u] = 1'b0; mdl_cnt[u] = 0;
        end

        // rst flush iv data ordy | ov data ir chk_ir occ
        add(1, 0, 0, 32'h00, 0,  0, 32'h00, 1, 0, 0);
        add(1, 0, 0, 32'h00, 0,  0, 32'h00, 1, 0, 0);
        add(0, 0, 1, 32'h11, 1,  1, 32'h11, 1, 1, 1);
        add(0, 0, 1, 32'h22, 1,  1, 32'h22, 1, 1, 1);
        add(0, 0, 1, 32'h33, 1,  1, 32'h33, 1, 1, 1);
        add(0, 0, 0, 32'h00, 1,  0, 32'h00, 1, 1, 0);
        add(0, 0, 1, 32'hA1, 0,  1, 32'hA1, 1, 1, 1);
        add(0, 0, 1, 32'hA2, 0,  1, 32'hA1, 0, 1, 2);
        add(0, 0, 1, 32'hA3, 0,  1, 32'hA1, 0, 1, 2);
        add(0, 0, 1, 32'hA3, 1,  1, 32'hA2, 1, 1, 1);
        add(0, 0, 1, 32'hA3, 1,  1, 32'hA3, 1, 1, 1);
        add(0, 0, 0, 32'h00, 1,  0, 32'h00, 1, 1, 0);
        add(0, 0, 1, 32'h55, 0,  1, 32'h55, 1, 1, 1);
        add(0, 0, 0, 32'h00, 1,  0, 32'h00, 1, 1, 0);
        add(0, 0, 1, 32'hB1, 0,  1, 32'hB1, 1, 1, 1);
        add(0, 0, 1, 32'hB2, 0,  1, 32'hB1, 0, 1, 2);
        add(0, 1, 1, 32'hB3, 0,  0, 32'h00, 1, 1, 0);
        add(0, 0, 0, 32'h00, 1,  0, 32'h00, 1, 1, 0);
        add(0, 0, 1, 32'hC1, 0,  1, 32'hC1, 1, 1, 1);
        add(0, 0, 1, 32'hC2, 0,  1, 32'hC1, 0, 1, 2);
        add(1, 0, 1, 32'hDD, 0,  0, 32'h00, 1, 0, 0);
        add(0, 0, 0, 32'h00, 0,  0, 32'h00, 1, 1, 0);
        add(0, 0, 1, 32'hE1, 1,  1, 32'hE1, 1, 1, 1);

        @(posedge clk);
        #1;
        for (int i = 0; i < tbl.size(); i++) begin
            rst_s[1] = tbl[i].rst; flush_s[1] = tbl[i].flush; iv_s[1] = tbl[i].iv;
            id_s[1] = tbl[i].d; ordy_s[1] = tbl[i].ordy;
            @(posedge clk);
            #1;
            chk($sformatf("vec%0d_out_valid", i), 32'(ov_s[1]), 32'(tbl[i].ov));
            chk($sformatf("vec%0d_out_data", i), od_s[1], tbl[i].od);
            chk($sformatf("vec%0d_occupancy", i), 32'(occ_s[1]), 32'(tbl[i].occ));
            if (tbl[i].chk_ir) chk($sformatf("vec%0d_in_ready", i), 32'(ir_s[1]), 32'(tbl[i].ir));
        end

        // SKID=0: continuous input with out_ready toggling 1,0,1.
        cyc(0, 1, 0, 0, 32'h0, 0);
        cyc(0, 1, 0, 0, 32'h0, 0);
        for (int i = 0; i < 9; i++) begin
            cyc(0, 0, 0, 1, 32'h100 + 32'(i), (i % 3) != 1);
        end

        // Random traffic on both variants.
        for (int u = 1; u >= 0; u--) begin
            cyc(u, 1, 0, 0, 32'h0, 0);
            cyc(u, 1, 0, 0, 32'h0, 0);
            for (int i = 0; i < 400; i++) begin
                cyc(u, ($urandom % 100) == 0, ($urandom % 25) == 0, ($urandom % 4) != 0,
                    $urandom, ($urandom % 3) != 0);
            end
            rst_s[u] = 1'b1; iv_s[u] = 1'b0; flush_s[u] = 1'b0; ordy_s[u] = 1'b0;
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
